// File: rtl/mem_wb_pipe_if.sv
// MEM->WB channel bundle: upstream (in_*) and downstream (out_*) valid/ready handshakes.
// The pipeline register chain takes the slave view; the surrounding MEM/WB logic takes the master view.
interface mem_wb_pipe_if #(
    parameter int unsigned WB_W   = 2,
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WB_W-1:0]   in_wb;
    logic [DATA_W-1:0] in_readdata;
    logic [DATA_W-1:0] in_aluout;
    logic              out_valid;
    logic              out_ready;
    logic [WB_W-1:0]   out_wb;
    logic [DATA_W-1:0] out_readdata;
    logic [DATA_W-1:0] out_aluout;

    modport master (
        output in_valid, in_wb, in_readdata, in_aluout, out_ready,
        input  in_ready, out_valid, out_wb, out_readdata, out_aluout
    );

    modport slave (
        input  in_valid, in_wb, in_readdata, in_aluout, out_ready,
        output in_ready, out_valid, out_wb, out_readdata, out_aluout
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// Elastic MEM->WB register chain of DEPTH stages with valid/ready back-pressure,
// bubble collapsing, synchronous flush and synchronous reset.
module mem_wb_pipe #(
    parameter int unsigned WB_W    = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 1,
    parameter int unsigned GATE_WB = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    mem_wb_pipe_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             v;
    logic [DEPTH-1:0][WB_W-1:0]   wb_q;
    logic [DEPTH-1:0][DATA_W-1:0] rd_q;
    logic [DEPTH-1:0][DATA_W-1:0] al_q;

    logic [DEPTH:0]               r;
    logic [DEPTH-1:0]             up_v;
    logic [DEPTH-1:0][WB_W-1:0]   up_wb;
    logic [DEPTH-1:0][DATA_W-1:0] up_rd;
    logic [DEPTH-1:0][DATA_W-1:0] up_al;

    // Ready ripples from the WB end back towards MEM; a stage is ready if empty or draining.
    always_comb begin
        r        = '0;
        r[DEPTH] = bus.out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            r[DEPTH-1-i] = ~v[DEPTH-1-i] | r[DEPTH-i];
        end
    end

    always_comb begin
        up_v     = '0;
        up_wb    = '0;
        up_rd    = '0;
        up_al    = '0;
        up_v[0]  = bus.in_valid;
        up_wb[0] = bus.in_wb;
        up_rd[0] = bus.in_readdata;
        up_al[0] = bus.in_aluout;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            up_v[k]  = v[k-1];
            up_wb[k] = wb_q[k-1];
            up_rd[k] = rd_q[k-1];
            up_al[k] = al_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= '0;
            wb_q <= '0;
            rd_q <= '0;
            al_q <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r[k]) begin
                    v[k] <= up_v[k];
                    // Payload only moves with a real entry so bubbles never overwrite data.
                    if (up_v[k]) begin
                        wb_q[k] <= up_wb[k];
                        rd_q[k] <= up_rd[k];
                        al_q[k] <= up_al[k];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(v[k]);
        end
    end

    assign bus.in_ready     = r[0] & ~flush;
    assign bus.out_valid    = v[DEPTH-1];
    assign bus.out_wb       = ((GATE_WB == 0) || v[DEPTH-1]) ? wb_q[DEPTH-1] : '0;
    assign bus.out_readdata = rd_q[DEPTH-1];
    assign bus.out_aluout   = al_q[DEPTH-1];
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed-vector bench for mem_wb_pipe: a DEPTH=3 chain and a DEPTH=1 chain,
// expected values worked out by hand per scenario.
module tb_mem_wb_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    mem_wb_pipe_if #(.WB_W(2), .DATA_W(32)) b3 ();
    mem_wb_pipe_if #(.WB_W(2), .DATA_W(32)) b1 ();
    logic [1:0] occ3;
    logic [0:0] occ1;

    mem_wb_pipe #(.WB_W(2), .DATA_W(32), .DEPTH(3), .GATE_WB(1)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b3.slave), .occupancy(occ3)
    );
    mem_wb_pipe #(.WB_W(2), .DATA_W(32), .DEPTH(1), .GATE_WB(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave), .occupancy(occ1)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input logic vld, input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] al);
        b3.in_valid    = vld;
        b3.in_wb       = wb;
        b3.in_readdata = rd;
        b3.in_aluout   = al;
    endtask

    task automatic idle3();
        drive3(1'b0, 2'b11, 32'hDEAD_DEAD, 32'hBEEF_BEEF);
    endtask

    int  k;
    int  exp_occ;
    logic m;
    logic exp_rdy;
    logic [31:0] md;

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idle3();
        b3.out_ready   = 1'b0;
        b1.in_valid    = 1'b0;
        b1.in_wb       = '0;
        b1.in_readdata = '0;
        b1.in_aluout   = '0;
        b1.out_ready   = 1'b0;

        // 1: reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid3", b3.out_valid, 0);
        chk("rst_wb3", b3.out_wb, 0);
        chk("rst_rd3", b3.out_readdata, 0);
        chk("rst_al3", b3.out_aluout, 0);
        chk("rst_occ3", occ3, 0);
        chk("rst_rdy3", b3.in_ready, 1);
        chk("rst_valid1", b1.out_valid, 0);
        chk("rst_occ1", occ1, 0);
        chk("rst_rdy1", b1.in_ready, 1);

        // 2: back-to-back stream, no stalls
        b3.out_ready = 1'b1;
        for (int t = 0; t < 7; t++) begin
            if (t < 4) drive3(1'b1, 2'b11, 32'h100 + t, 32'h11 * (t + 1));
            else       idle3();
            #1;
            chk("s2_in_ready", b3.in_ready, 1);
            tick();
            k = t - 2;
            exp_occ = 0;
            for (int e = 0; e < 4; e++) if (t - e >= 0 && t - e <= 2) exp_occ++;
            chk("s2_occ", occ3, exp_occ);
            if (k >= 0 && k < 4) begin
                chk("s2_valid", b3.out_valid, 1);
                chk("s2_al", b3.out_aluout, 32'h11 * (k + 1));
                chk("s2_rd", b3.out_readdata, 32'h100 + k);
                chk("s2_wb", b3.out_wb, 2'b11);
            end else begin
                chk("s2_valid_idle", b3.out_valid, 0);
                chk("s2_wb_gated", b3.out_wb, 0);
            end
        end

        // 3: stall with full chain, then release
        b3.out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive3(1'b1, 2'b01, 32'hA0 + t, 32'hA + t);
            tick();
        end
        drive3(1'b1, 2'b01, 32'hD0, 32'hD);
        #1;
        chk("s3_full_rdy", b3.in_ready, 0);
        tick();
        chk("s3_hold_al", b3.out_aluout, 32'hA);
        chk("s3_hold_occ", occ3, 3);
        tick();
        chk("s3_hold_al2", b3.out_aluout, 32'hA);
        chk("s3_hold_rd2", b3.out_readdata, 32'hA0);
        b3.out_ready = 1'b1;
        #1;
        chk("s3_pass_rdy", b3.in_ready, 1);
        tick();
        chk("s3_al_B", b3.out_aluout, 32'hB);
        idle3();
        tick();
        chk("s3_al_C", b3.out_aluout, 32'hC);
        tick();
        chk("s3_al_D", b3.out_aluout, 32'hD);
        chk("s3_rd_D", b3.out_readdata, 32'hD0);
        chk("s3_valid_D", b3.out_valid, 1);
        tick();
        chk("s3_drained", b3.out_valid, 0);
        chk("s3_occ0", occ3, 0);

        // 4: bubble collapse
        b3.out_ready = 1'b0;
        drive3(1'b1, 2'b01, 32'h151, 32'h51);
        tick();
        idle3();
        tick();
        tick();
        drive3(1'b1, 2'b01, 32'h152, 32'h52);
        tick();
        idle3();
        tick();
        chk("s4_occ", occ3, 2);
        chk("s4_al_E1", b3.out_aluout, 32'h51);
        b3.out_ready = 1'b1;
        tick();
        chk("s4_al_E2", b3.out_aluout, 32'h52);
        chk("s4_valid_E2", b3.out_valid, 1);
        chk("s4_occ1", occ3, 1);
        tick();
        chk("s4_occ0", occ3, 0);

        // 5: flush on a full chain with a live input
        b3.out_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            drive3(1'b1, 2'b11, 32'h161 + t, 32'h61 + t);
            tick();
        end
        chk("s5_full_occ", occ3, 3);
        flush = 1'b1;
        drive3(1'b1, 2'b11, 32'h16F, 32'h6F);
        #1;
        chk("s5_flush_rdy", b3.in_ready, 0);
        tick();
        flush = 1'b0;
        idle3();
        chk("s5_occ", occ3, 0);
        chk("s5_valid", b3.out_valid, 0);
        chk("s5_wb", b3.out_wb, 0);
        chk("s5_al_held", b3.out_aluout, 32'h61);
        b3.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("s5_no_ghost", b3.out_valid, 0);
        end

        // 6a: rst and flush together mid-stream
        for (int t = 0; t < 3; t++) begin
            drive3(1'b1, 2'b11, 32'h171 + t, 32'h71 + t);
            tick();
        end
        chk("s6_pre_al", b3.out_aluout, 32'h71);
        rst   = 1'b1;
        flush = 1'b1;
        drive3(1'b1, 2'b11, 32'h174, 32'h74);
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        idle3();
        #1;
        chk("s6_al0", b3.out_aluout, 0);
        chk("s6_rd0", b3.out_readdata, 0);
        chk("s6_wb0", b3.out_wb, 0);
        chk("s6_valid0", b3.out_valid, 0);
        chk("s6_occ0", occ3, 0);
        chk("s6_rdy1", b3.in_ready, 1);

        // 6b: DEPTH=1 with out_ready toggling, reference single-slot model
        m  = 1'b0;
        md = '0;
        b1.in_valid = 1'b1;
        b1.in_wb    = 2'b10;
        for (int c = 0; c < 8; c++) begin
            b1.out_ready   = c[0];
            b1.in_aluout   = 32'h80 + c;
            b1.in_readdata = 32'h180 + c;
            #1;
            exp_rdy = ~m | b1.out_ready;
            chk("d1_in_ready", b1.in_ready, exp_rdy);
            if (m && b1.out_ready) m = 1'b0;
            if (exp_rdy) begin
                m  = 1'b1;
                md = 32'h80 + c;
            end
            tick();
            chk("d1_valid", b1.out_valid, m);
            chk("d1_occ", occ1, m);
            if (m) begin
                chk("d1_al", b1.out_aluout, md);
                chk("d1_wb", b1.out_wb, 2'b10);
            end
        end
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        tick();
        chk("d1_drained", b1.out_valid, 0);
        chk("d1_wb_gated", b1.out_wb, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
